// File: rtl/tl_pkg.sv
// Shared definitions for the two-road phase scheduler.
// Holds the phase encodings, the lamp-vector bit order and the lamp decode.
package tl_pkg;

  typedef enum logic [2:0] {
    ST_G1    = 3'd0,
    ST_Y1    = 3'd1,
    ST_AR1   = 3'd2,
    ST_G2    = 3'd3,
    ST_Y2    = 3'd4,
    ST_AR2   = 3'd5,
    ST_FLASH = 3'd6,
    ST_BAD   = 3'd7
  } tl_state_e;

  // Lamp vector is {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
  localparam int LAMP_W = 6;
  localparam int L_GRN1 = 5;
  localparam int L_YLW1 = 4;
  localparam int L_RED1 = 3;
  localparam int L_GRN2 = 2;
  localparam int L_YLW2 = 1;
  localparam int L_RED2 = 0;

  typedef logic [LAMP_W-1:0] lamp_t;

  function automatic lamp_t lamp_decode(input tl_state_e st, input logic flash);
    lamp_t l;
    l = '0;
    case (st)
      ST_G1: begin
        l[L_GRN1] = 1'b1;
        l[L_RED2] = 1'b1;
      end
      ST_Y1: begin
        l[L_YLW1] = 1'b1;
        l[L_RED2] = 1'b1;
      end
      ST_G2: begin
        l[L_GRN2] = 1'b1;
        l[L_RED1] = 1'b1;
      end
      ST_Y2: begin
        l[L_YLW2] = 1'b1;
        l[L_RED1] = 1'b1;
      end
      ST_FLASH: begin
        l[L_YLW1] = flash;
        l[L_YLW2] = flash;
      end
      default: begin
        // all-red phases, and all-red as the safe fallback for the unused code
        l[L_RED1] = 1'b1;
        l[L_RED2] = 1'b1;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Timing-tick source: free-running prescaler that wraps every PRESCALE cycles,
// bypassed in test mode so every clock is a tick.
module tl_tick_gen #(
  parameter int PRESCALE = 16
) (
  input  logic ck,
  input  logic clr,
  input  logic test,
  output logic tick,
  output logic tick_q
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          wrap;

  assign wrap = (pcnt == PMAX);
  assign tick = test | wrap;

  always_ff @(posedge ck or posedge clr) begin
    if (clr) begin
      pcnt   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
      if (test || wrap) pcnt <= '0;
      else              pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/tl_phase_sched.sv
// Two-road intersection phase scheduler: request arbitration, minimum intervals,
// flash mode and registered lamp drive. Define TL_INPUT_SYNC_EN to synchronise inputs.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int PRESCALE  = 16,
  parameter int GREEN_MIN = 4,
  parameter int YLW_T     = 2,
  parameter int ALLRED_T  = 1,
  parameter int CW        = 4
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       FM,
  input  logic       TEST,
  input  logic       REQ1,
  input  logic       REQ2,
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic [2:0] PHASE,
  output logic       TICK
);

  localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] YLW_M1  = CW'(YLW_T - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic fm;
  logic test;
  logic req1;
  logic req2;

`ifdef TL_INPUT_SYNC_EN
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;

  // two-flop synchroniser for the asynchronous field inputs
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {FM, TEST, REQ1, REQ2};
      sync_p1 <= sync_p0;
    end
  end

  assign {fm, test, req1, req2} = sync_p1;
`else
  assign fm   = FM;
  assign test = TEST;
  assign req1 = REQ1;
  assign req2 = REQ2;
`endif

  logic tick;

  tl_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .ck    (CK),
    .clr   (CLR),
    .test  (test),
    .tick  (tick),
    .tick_q(TICK)
  );

  tl_state_e     state;
  tl_state_e     state_nxt;
  logic [CW-1:0] cnt;
  logic          flash;
  logic          flash_nxt;
  logic          pend1;
  logic          pend2;
  lamp_t         lamp_nxt;
  lamp_t         lamp_q;

  // State register: phase, interval counter, flash bit and lamp drive
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state  <= ST_AR2;
      cnt    <= '0;
      flash  <= 1'b0;
      lamp_q <= lamp_decode(ST_AR2, 1'b0);
    end else begin
      state  <= state_nxt;
      flash  <= flash_nxt;
      lamp_q <= lamp_nxt;
      if (state_nxt != state)           cnt <= '0;
      else if (tick && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic; nothing moves except on a tick
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        ST_G1:    if (fm || (cnt >= GMIN_M1 && pend2)) state_nxt = ST_Y1;
        ST_Y1:    if (cnt == YLW_M1)                   state_nxt = ST_AR1;
        ST_AR1: begin
          if (fm)                  state_nxt = ST_FLASH;
          else if (cnt == AR_M1)   state_nxt = ST_G2;
        end
        ST_G2:    if (fm || (cnt >= GMIN_M1 && pend1)) state_nxt = ST_Y2;
        ST_Y2:    if (cnt == YLW_M1)                   state_nxt = ST_AR2;
        ST_AR2: begin
          if (fm)                  state_nxt = ST_FLASH;
          else if (cnt == AR_M1)   state_nxt = ST_G1;
        end
        ST_FLASH: if (!fm)                             state_nxt = ST_AR2;
        default:                                       state_nxt = ST_AR2;
      endcase
    end
  end

  // Output logic: lamps follow the phase being entered, so they switch with it
  always_comb begin
    flash_nxt = flash;
    if (state_nxt == ST_FLASH && state != ST_FLASH) flash_nxt = 1'b0;
    else if (state == ST_FLASH && tick)             flash_nxt = ~flash;
    lamp_nxt = lamp_decode(state_nxt, flash_nxt);
  end

  // Request latches: a request arriving on the serving edge is kept
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      pend1 <= req1 | (pend1 & ~(state_nxt == ST_G1 && state != ST_G1));
      pend2 <= req2 | (pend2 & ~(state_nxt == ST_G2 && state != ST_G2));
    end
  end

  assign GRN1  = lamp_q[L_GRN1];
  assign YLW1  = lamp_q[L_YLW1];
  assign RED1  = lamp_q[L_RED1];
  assign GRN2  = lamp_q[L_GRN2];
  assign YLW2  = lamp_q[L_YLW2];
  assign RED2  = lamp_q[L_RED2];
  assign PHASE = state;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Scoreboard bench for tl_phase_sched: directed scenarios queue timestamped
// expectations, a negedge monitor pops and compares them against the lamps.
module tb_tl_phase_sched;

  logic       CK   = 1'b0;
  logic       CLR  = 1'b0;
  logic       FM   = 1'b0;
  logic       TEST = 1'b0;
  logic       REQ1 = 1'b0;
  logic       REQ2 = 1'b0;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic [2:0] PHASE;
  logic       TICK;

  tl_phase_sched #(
    .PRESCALE (16),
    .GREEN_MIN(4),
    .YLW_T    (2),
    .ALLRED_T (1),
    .CW       (4)
  ) dut (
    .CK   (CK),
    .CLR  (CLR),
    .FM   (FM),
    .TEST (TEST),
    .REQ1 (REQ1),
    .REQ2 (REQ2),
    .GRN1 (GRN1),
    .YLW1 (YLW1),
    .RED1 (RED1),
    .GRN2 (GRN2),
    .YLW2 (YLW2),
    .RED2 (RED2),
    .PHASE(PHASE),
    .TICK (TICK)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
  localparam logic [5:0] LG1  = 6'b100001;
  localparam logic [5:0] LY1  = 6'b010001;
  localparam logic [5:0] LAR  = 6'b001001;
  localparam logic [5:0] LG2  = 6'b001100;
  localparam logic [5:0] LY2  = 6'b001010;
  localparam logic [5:0] LFL1 = 6'b010010;
  localparam logic [5:0] LFL0 = 6'b000000;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic [5:0] lamps;
    logic       tk;
    logic       chk_tk;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rel         = 0;

  logic [5:0] lamps;
  logic [2:0] last_ph = 3'd5;
  assign lamps = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};

  task automatic push(input int c, input logic [2:0] ph, input logic [5:0] l,
                      input logic tk, input logic chk_tk, input string nm);
    exp_t e;
    e.cyc = c; e.ph = ph; e.lamps = l; e.tk = tk; e.chk_tk = chk_tk; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CK);
      #1;
    end
  endtask

  // Called just after a rising edge; CLR goes high mid-cycle so the
  // negedge check in this same cycle sees the asynchronous effect.
  task automatic apply_reset(input logic tst, input logic r1, input logic r2);
    CLR = 1'b1; TEST = tst; FM = 1'b0; REQ1 = 1'b0; REQ2 = 1'b0;
    push(cyc, 3'd5, LAR, 1'b0, 1'b1, "reset_state");
    @(posedge CK); #1;
    @(posedge CK); #1;
    CLR = 1'b0; REQ1 = r1; REQ2 = r2;
    rel = cyc;
  endtask

  // Monitor
  always @(negedge CK) begin
    exp_t e;
    bit   matched;
    matched = 1'b0;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      vectors++;
      if (e.cyc != cyc || PHASE !== e.ph || lamps !== e.lamps ||
          (e.chk_tk && TICK !== e.tk)) begin
        miscompares++;
        $display("FAIL %s cyc=%0d: got phase=%0d lamps=%b tick=%b, want cyc=%0d phase=%0d lamps=%b tick=%b",
                 e.nm, cyc, PHASE, lamps, TICK, e.cyc, e.ph, e.lamps, e.tk);
      end
      if (e.cyc == cyc) matched = 1'b1;
    end
    if (PHASE !== last_ph) begin
      vectors++;
      if (!matched) begin
        miscompares++;
        $display("FAIL unexpected_phase_change cyc=%0d: got phase=%0d from %0d, want no change",
                 cyc, PHASE, last_ph);
      end
    end
    last_ph = PHASE;
    vectors++;
    if ((GRN1 === 1'b1 && GRN2 === 1'b1) || (GRN1 === 1'b1 && RED2 !== 1'b1) ||
        (GRN2 === 1'b1 && RED1 !== 1'b1)) begin
      miscompares++;
      $display("FAIL safety cyc=%0d: got lamps=%b, want no conflicting green", cyc, lamps);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge CK); #1;

    // Test mode, no requests: G1 on the first edge, then rests
    apply_reset(1'b1, 1'b0, 1'b0);
    push(rel + 1,  3'd0, LG1, 1'b1, 1'b1, "s1_g1_entry");
    push(rel + 50, 3'd0, LG1, 1'b1, 1'b1, "s1_g1_rest");
    wait_cyc(rel + 52);

    // REQ2 pulse serves road 2, then FM during G2 goes through Y2/AR2 to flash
    apply_reset(1'b1, 1'b0, 1'b0);
    push(rel + 1,  3'd0, LG1,  1'b1, 1'b0, "s2_g1");
    push(rel + 5,  3'd1, LY1,  1'b1, 1'b0, "s2_y1");
    push(rel + 7,  3'd2, LAR,  1'b1, 1'b0, "s2_ar1");
    push(rel + 8,  3'd3, LG2,  1'b1, 1'b0, "s2_g2");
    push(rel + 13, 3'd4, LY2,  1'b1, 1'b0, "s4_y2");
    push(rel + 15, 3'd5, LAR,  1'b1, 1'b0, "s4_ar2");
    push(rel + 16, 3'd6, LFL0, 1'b1, 1'b0, "s4_flash_entry");
    push(rel + 17, 3'd6, LFL1, 1'b1, 1'b0, "s4_flash_on");
    push(rel + 18, 3'd6, LFL0, 1'b1, 1'b0, "s4_flash_off");
    push(rel + 19, 3'd6, LFL1, 1'b1, 1'b0, "s4_flash_on2");
    push(rel + 20, 3'd5, LAR,  1'b1, 1'b0, "s4_exit_ar2");
    push(rel + 21, 3'd0, LG1,  1'b1, 1'b0, "s4_g1");
    push(rel + 35, 3'd0, LG1,  1'b1, 1'b0, "s4_g1_rest_pend2_clear");
    wait_cyc(rel + 1);  REQ2 = 1'b1;
    wait_cyc(rel + 2);  REQ2 = 1'b0;
    wait_cyc(rel + 12); FM = 1'b1;
    wait_cyc(rel + 19); FM = 1'b0;
    wait_cyc(rel + 36);

    // Both requests during AR2: road 1 first, road 2 next, then road 1 again
    apply_reset(1'b1, 1'b1, 1'b1);
    push(rel + 1,  3'd0, LG1, 1'b1, 1'b0, "s5_g1_first");
    push(rel + 5,  3'd1, LY1, 1'b1, 1'b0, "s5_y1");
    push(rel + 7,  3'd2, LAR, 1'b1, 1'b0, "s5_ar1");
    push(rel + 8,  3'd3, LG2, 1'b1, 1'b0, "s5_g2");
    push(rel + 12, 3'd4, LY2, 1'b1, 1'b0, "s5_y2_pend1_kept");
    push(rel + 14, 3'd5, LAR, 1'b1, 1'b0, "s5_ar2");
    push(rel + 15, 3'd0, LG1, 1'b1, 1'b0, "s5_g1_again");
    push(rel + 25, 3'd0, LG1, 1'b1, 1'b0, "s5_g1_rest");
    wait_cyc(rel + 1); REQ1 = 1'b0; REQ2 = 1'b0;
    wait_cyc(rel + 26);

    // Prescaled timing with REQ2 held, then CLR in the middle of Y1
    apply_reset(1'b0, 1'b0, 1'b1);
    push(rel + 15, 3'd5, LAR, 1'b0, 1'b1, "s3_ar2_before_tick");
    push(rel + 16, 3'd0, LG1, 1'b1, 1'b1, "s3_g1_at_16");
    push(rel + 17, 3'd0, LG1, 1'b0, 1'b1, "s3_tick_drop");
    push(rel + 80, 3'd1, LY1, 1'b1, 1'b1, "s3_y1_at_80");
    push(rel + 81, 3'd1, LY1, 1'b0, 1'b1, "s3_y1_hold");
    wait_cyc(rel + 82); REQ2 = 1'b0;
    wait_cyc(rel + 85);
    apply_reset(1'b0, 1'b0, 1'b0);
    push(rel + 10, 3'd5, LAR, 1'b0, 1'b1, "s6_restart_ar2");
    push(rel + 16, 3'd0, LG1, 1'b1, 1'b1, "s6_restart_g1");
    wait_cyc(rel + 20);

    @(posedge CK); #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
